// File: rtl/art_select_ctrl.sv
// art_select_ctrl: Wishbone-controlled selector that enables at most one art
// macro at a time. Every switch between macros passes through an all-off gap
// of GAP_CYCLES cycles, so two macros are never enabled together. An optional
// period makes the selection rotate through the macros automatically.
module art_select_ctrl #(
  parameter int          N_MACROS   = 4,
  parameter int          GAP_CYCLES = 4,
  parameter logic [31:0] BASE_ADR   = 32'h3000_0000
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                wbs_cyc_i,
  input  logic                wbs_stb_i,
  input  logic                wbs_we_i,
  input  logic [3:0]          wbs_sel_i,
  input  logic [31:0]         wbs_adr_i,
  input  logic [31:0]         wbs_dat_i,
  output logic                wbs_ack_o,
  output logic [31:0]         wbs_dat_o,
  output logic [N_MACROS-1:0] active_o
);

  // State values double as the STATUS state code.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

  localparam logic [3:0] LAST_IDX_C = 4'(N_MACROS - 1);
  localparam logic [7:0] GAP_LAST_C = 8'(GAP_CYCLES - 1);

  state_t              state_r;
  logic [3:0]          sel_r;
  logic [3:0]          cur_r;
  logic                en_r;
  logic [15:0]         period_r;
  logic [7:0]          gap_cnt_r;
  logic [15:0]         per_cnt_r;
  logic [N_MACROS-1:0] active_r;
  logic                ack_r;
  logic [31:0]         dat_r;

  logic                hit_s;
  logic                fire_s;
  logic                wr_ctrl_s;
  logic                wr_per_s;
  logic                sel_ok_s;
  logic                per_last_s;
  logic [3:0]          next_idx_s;
  logic [31:0]         rdata_s;
  logic                unused_s;

  // One-hot enable pattern for a macro index.
  function automatic logic [N_MACROS-1:0] onehot_f(input logic [3:0] idx);
    onehot_f = {{(N_MACROS-1){1'b0}}, 1'b1} << idx;
  endfunction

  // A request is served on the cycle it is seen with ack low; the write and
  // the ack happen on the same edge, so a held request re-acks every other cycle.
  assign hit_s      = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADR[31:4]);
  assign fire_s     = hit_s & ~ack_r;
  assign wr_ctrl_s  = fire_s & wbs_we_i & (wbs_adr_i[3:2] == 2'd0);
  assign wr_per_s   = fire_s & wbs_we_i & (wbs_adr_i[3:2] == 2'd1);
  assign sel_ok_s   = (wbs_dat_i[3:0] <= LAST_IDX_C);
  assign per_last_s = (period_r != 16'd0) && (per_cnt_r == (period_r - 16'd1));
  assign next_idx_s = (cur_r == LAST_IDX_C) ? 4'd0 : (cur_r + 4'd1);
  assign unused_s   = ^{wbs_adr_i[1:0], wbs_sel_i[3:2], wbs_dat_i[31:16]};

  assign wbs_ack_o = ack_r;
  assign wbs_dat_o = dat_r;
  assign active_o  = active_r;

  // Read data mux, sampled into the output register on the acking edge.
  always_comb begin
    rdata_s = 32'd0;
    case (wbs_adr_i[3:2])
      2'd0:    rdata_s = {23'd0, en_r, 4'd0, sel_r};
      2'd1:    rdata_s = {16'd0, period_r};
      2'd2:    rdata_s = {15'd0, (state_r == ST_GAP), 6'd0, state_r, 4'd0, cur_r};
      default: rdata_s = 32'd0;
    endcase
  end

  // Wishbone acknowledge and read data registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_r <= 1'b0;
      dat_r <= 32'd0;
    end else begin
      ack_r <= fire_s;
      dat_r <= fire_s ? rdata_s : 32'd0;
    end
  end

  // Register file and selection FSM; register writes are applied after the
  // FSM step so a same-edge SEL write overrides the rotation target.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_r   <= ST_IDLE;
      sel_r     <= 4'd0;
      cur_r     <= 4'd0;
      en_r      <= 1'b0;
      period_r  <= 16'd0;
      gap_cnt_r <= 8'd0;
      per_cnt_r <= 16'd0;
      active_r  <= {N_MACROS{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          gap_cnt_r <= 8'd0;
          per_cnt_r <= 16'd0;
          active_r  <= {N_MACROS{1'b0}};
          if (en_r) begin
            state_r <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (!en_r) begin
            state_r   <= ST_IDLE;
            gap_cnt_r <= 8'd0;
            per_cnt_r <= 16'd0;
            active_r  <= {N_MACROS{1'b0}};
          end else if (gap_cnt_r == GAP_LAST_C) begin
            state_r   <= ST_ACTIVE;
            cur_r     <= sel_r;
            gap_cnt_r <= 8'd0;
            per_cnt_r <= 16'd0;
            active_r  <= onehot_f(sel_r);
          end else begin
            gap_cnt_r <= gap_cnt_r + 8'd1;
          end
        end
        ST_ACTIVE: begin
          if (!en_r) begin
            state_r   <= ST_IDLE;
            gap_cnt_r <= 8'd0;
            per_cnt_r <= 16'd0;
            active_r  <= {N_MACROS{1'b0}};
          end else if (sel_r != cur_r) begin
            state_r   <= ST_GAP;
            gap_cnt_r <= 8'd0;
            active_r  <= {N_MACROS{1'b0}};
          end else if (per_last_s) begin
            state_r   <= ST_GAP;
            sel_r     <= next_idx_s;
            gap_cnt_r <= 8'd0;
            active_r  <= {N_MACROS{1'b0}};
          end else if (period_r != 16'd0) begin
            per_cnt_r <= per_cnt_r + 16'd1;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          active_r <= {N_MACROS{1'b0}};
        end
      endcase

      if (wr_ctrl_s) begin
        if (wbs_sel_i[0] && sel_ok_s) begin
          sel_r <= wbs_dat_i[3:0];
        end
        if (wbs_sel_i[1]) begin
          en_r <= wbs_dat_i[8];
        end
      end

      if (wr_per_s) begin
        if (wbs_sel_i[0]) begin
          period_r[7:0] <= wbs_dat_i[7:0];
        end
        if (wbs_sel_i[1]) begin
          period_r[15:8] <= wbs_dat_i[15:8];
        end
        per_cnt_r <= 16'd0;
      end
    end
  end

endmodule
